// File: rtl/alu_rs_if.sv
// Bundles issue, LSB snoop, ALU request/return and result-broadcast signals of the ALU reservation station.
interface alu_rs_if #(
  parameter int ROB_WIDTH = 4
);
  logic                 rdy_in;
  logic                 flush;
  logic                 issue_valid;
  logic [5:0]           issue_op;
  logic [31:0]          issue_vj;
  logic                 issue_qj_valid;
  logic [ROB_WIDTH-1:0] issue_qj;
  logic [31:0]          issue_vk;
  logic                 issue_qk_valid;
  logic [ROB_WIDTH-1:0] issue_qk;
  logic [31:0]          issue_imm;
  logic [ROB_WIDTH-1:0] issue_tag;
  logic                 rs_full;
  logic                 lsb_valid;
  logic [ROB_WIDTH-1:0] lsb_tag;
  logic [31:0]          lsb_value;
  logic                 alu_waiting;
  logic [5:0]           alu_op;
  logic [31:0]          alu_vj;
  logic [31:0]          alu_vk;
  logic [31:0]          alu_imm;
  logic                 alu_finish_rdy;
  logic [31:0]          alu_value;
  logic                 out_valid;
  logic [ROB_WIDTH-1:0] out_tag;
  logic [31:0]          out_value;

  modport slave (
    input  rdy_in, flush,
    input  issue_valid, issue_op, issue_vj, issue_qj_valid, issue_qj,
    input  issue_vk, issue_qk_valid, issue_qk, issue_imm, issue_tag,
    output rs_full,
    input  lsb_valid, lsb_tag, lsb_value,
    output alu_waiting, alu_op, alu_vj, alu_vk, alu_imm,
    input  alu_finish_rdy, alu_value,
    output out_valid, out_tag, out_value
  );

  modport master (
    output rdy_in, flush,
    output issue_valid, issue_op, issue_vj, issue_qj_valid, issue_qj,
    output issue_vk, issue_qk_valid, issue_qk, issue_imm, issue_tag,
    input  rs_full,
    output lsb_valid, lsb_tag, lsb_value,
    input  alu_waiting, alu_op, alu_vj, alu_vk, alu_imm,
    output alu_finish_rdy, alu_value,
    input  out_valid, out_tag, out_value
  );
endinterface

// File: rtl/alu_rs.sv
// ALU reservation station: issue->alu_waiting 2 cycles, ->out_valid 3 cycles; issue dropped while rs_full,
// whole block frozen while rdy_in is low.
module alu_rs #(
  parameter int RS_SIZE   = 16,
  parameter int ROB_WIDTH = 4
) (
  input logic     clk_in,
  input logic     rst_in,
  alu_rs_if.slave bus
);
  localparam int IDX_W = $clog2(RS_SIZE);

  typedef struct packed {
    logic [5:0]           op;
    logic [31:0]          vj;
    logic                 qj_valid;
    logic [ROB_WIDTH-1:0] qj;
    logic [31:0]          vk;
    logic                 qk_valid;
    logic [ROB_WIDTH-1:0] qk;
    logic [31:0]          imm;
    logic [ROB_WIDTH-1:0] tag;
  } entry_t;

  logic [RS_SIZE-1:0]   r_busy;
  entry_t               r_ent [RS_SIZE];
  logic                 r_alu_waiting;
  logic [5:0]           r_alu_op;
  logic [31:0]          r_alu_vj;
  logic [31:0]          r_alu_vk;
  logic [31:0]          r_alu_imm;
  logic                 r_pipe_valid;
  logic [ROB_WIDTH-1:0] r_pipe_tag;
  logic [ROB_WIDTH-1:0] r_out_tag;

  logic                 w_full;
  logic                 w_out_valid;
  logic                 w_issue_acc;
  logic                 w_disp_vld;
  logic [IDX_W-1:0]     w_free_idx;
  logic [IDX_W-1:0]     w_disp_idx;
  logic [RS_SIZE-1:0]   w_ready;
  entry_t               w_new;

  assign w_full      = &r_busy;
  assign w_out_valid = bus.alu_finish_rdy & r_pipe_valid;
  assign w_issue_acc = bus.issue_valid & ~w_full & ~bus.flush;

  assign bus.rs_full     = w_full;
  assign bus.alu_waiting = r_alu_waiting;
  assign bus.alu_op      = r_alu_op;
  assign bus.alu_vj      = r_alu_vj;
  assign bus.alu_vk      = r_alu_vk;
  assign bus.alu_imm     = r_alu_imm;
  assign bus.out_valid   = w_out_valid;
  assign bus.out_tag     = r_out_tag;
  assign bus.out_value   = bus.alu_value;

  // Scanning downwards leaves the lowest matching index in each selector.
  always_comb begin
    w_ready    = '0;
    w_free_idx = '0;
    w_disp_vld = 1'b0;
    w_disp_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      w_ready[i] = r_busy[i] & ~r_ent[i].qj_valid & ~r_ent[i].qk_valid;
      if (!r_busy[i]) w_free_idx = IDX_W'(i);
      if (w_ready[i]) begin
        w_disp_vld = 1'b1;
        w_disp_idx = IDX_W'(i);
      end
    end
  end

  // Operands resolved by a same-cycle broadcast are captured at issue; ALU result wins over LSB.
  always_comb begin
    w_new.op       = bus.issue_op;
    w_new.vj       = bus.issue_vj;
    w_new.qj_valid = bus.issue_qj_valid;
    w_new.qj       = bus.issue_qj;
    w_new.vk       = bus.issue_vk;
    w_new.qk_valid = bus.issue_qk_valid;
    w_new.qk       = bus.issue_qk;
    w_new.imm      = bus.issue_imm;
    w_new.tag      = bus.issue_tag;
    if (bus.issue_qj_valid) begin
      if (w_out_valid && r_out_tag == bus.issue_qj) begin
        w_new.vj       = bus.alu_value;
        w_new.qj_valid = 1'b0;
      end else if (bus.lsb_valid && bus.lsb_tag == bus.issue_qj) begin
        w_new.vj       = bus.lsb_value;
        w_new.qj_valid = 1'b0;
      end
    end
    if (bus.issue_qk_valid) begin
      if (w_out_valid && r_out_tag == bus.issue_qk) begin
        w_new.vk       = bus.alu_value;
        w_new.qk_valid = 1'b0;
      end else if (bus.lsb_valid && bus.lsb_tag == bus.issue_qk) begin
        w_new.vk       = bus.lsb_value;
        w_new.qk_valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_busy        <= '0;
      for (int i = 0; i < RS_SIZE; i++) r_ent[i] <= '0;
      r_alu_waiting <= 1'b0;
      r_alu_op      <= '0;
      r_alu_vj      <= '0;
      r_alu_vk      <= '0;
      r_alu_imm     <= '0;
      r_pipe_valid  <= 1'b0;
      r_pipe_tag    <= '0;
      r_out_tag     <= '0;
    end else if (bus.rdy_in) begin
      if (bus.flush) begin
        r_busy        <= '0;
        r_alu_waiting <= 1'b0;
        r_pipe_valid  <= 1'b0;
      end else begin
        r_pipe_valid <= r_alu_waiting;
        r_out_tag    <= r_pipe_tag;
        for (int i = 0; i < RS_SIZE; i++) begin
          if (r_busy[i] && r_ent[i].qj_valid) begin
            if (w_out_valid && r_out_tag == r_ent[i].qj) begin
              r_ent[i].vj       <= bus.alu_value;
              r_ent[i].qj_valid <= 1'b0;
            end else if (bus.lsb_valid && bus.lsb_tag == r_ent[i].qj) begin
              r_ent[i].vj       <= bus.lsb_value;
              r_ent[i].qj_valid <= 1'b0;
            end
          end
          if (r_busy[i] && r_ent[i].qk_valid) begin
            if (w_out_valid && r_out_tag == r_ent[i].qk) begin
              r_ent[i].vk       <= bus.alu_value;
              r_ent[i].qk_valid <= 1'b0;
            end else if (bus.lsb_valid && bus.lsb_tag == r_ent[i].qk) begin
              r_ent[i].vk       <= bus.lsb_value;
              r_ent[i].qk_valid <= 1'b0;
            end
          end
        end
        if (w_disp_vld) begin
          r_alu_waiting      <= 1'b1;
          r_alu_op           <= r_ent[w_disp_idx].op;
          r_alu_vj           <= r_ent[w_disp_idx].vj;
          r_alu_vk           <= r_ent[w_disp_idx].vk;
          r_alu_imm          <= r_ent[w_disp_idx].imm;
          r_pipe_tag         <= r_ent[w_disp_idx].tag;
          r_busy[w_disp_idx] <= 1'b0;
        end else begin
          r_alu_waiting <= 1'b0;
        end
        // The free slot is never the dispatched or a woken one, so these writes cannot collide.
        if (w_issue_acc) begin
          r_busy[w_free_idx] <= 1'b1;
          r_ent[w_free_idx]  <= w_new;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs; includes a one-cycle ALU model answering alu_waiting requests.
module tb_alu_rs;
  logic clk_in;
  logic rst_in;
  int   n_checks;
  int   n_fail;

  alu_rs_if #(.ROB_WIDTH(4)) bus ();

  alu_rs #(.RS_SIZE(16), .ROB_WIDTH(4)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] alu_calc(input logic [5:0] op, input logic [31:0] vj,
                                           input logic [31:0] vk, input logic [31:0] imm);
    case (op[1:0])
      2'b01:   alu_calc = vj + imm;
      2'b11:   alu_calc = op[5] ? (vj - vk) : (vj + vk);
      default: alu_calc = imm;
    endcase
  endfunction

  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      bus.alu_finish_rdy <= 1'b0;
      bus.alu_value      <= '0;
    end else if (bus.rdy_in) begin
      bus.alu_finish_rdy <= bus.alu_waiting;
      if (bus.alu_waiting) bus.alu_value <= alu_calc(bus.alu_op, bus.alu_vj, bus.alu_vk, bus.alu_imm);
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_issue(input logic [5:0] op, input logic [31:0] vj, input logic qjv,
                          input logic [3:0] qj, input logic [31:0] vk, input logic qkv,
                          input logic [3:0] qk, input logic [31:0] imm, input logic [3:0] tag);
    bus.issue_valid    = 1'b1;
    bus.issue_op       = op;
    bus.issue_vj       = vj;
    bus.issue_qj_valid = qjv;
    bus.issue_qj       = qj;
    bus.issue_vk       = vk;
    bus.issue_qk_valid = qkv;
    bus.issue_qk       = qk;
    bus.issue_imm      = imm;
    bus.issue_tag      = tag;
  endtask

  task automatic idle();
    bus.issue_valid = 1'b0;
    bus.lsb_valid   = 1'b0;
    bus.flush       = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    #2;
    n_checks++; if (bus.alu_waiting !== 1'b0) begin n_fail++; $display("FAIL rst_waiting: got %0d want 0", bus.alu_waiting); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %0d want 0", bus.out_valid); end
    n_checks++; if (bus.rs_full !== 1'b0) begin n_fail++; $display("FAIL rst_full: got %0d want 0", bus.rs_full); end
    n_checks++; if (bus.alu_vj !== 32'd0 || bus.alu_op !== 6'd0 || bus.out_tag !== 4'd0)
      begin n_fail++; $display("FAIL rst_regs: vj=%0h op=%0h tag=%0h want 0", bus.alu_vj, bus.alu_op, bus.out_tag); end
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    tick();
    // Mid-dispatch async reset; a pending entry must also disappear.
    do_issue(6'b000001, 32'd1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd1, 4'd3);
    tick();
    do_issue(6'b000011, 32'd0, 1'b1, 4'd8, 32'd2, 1'b0, 4'd0, 32'd0, 4'd5);
    tick();
    idle();
    n_checks++; if (bus.alu_waiting !== 1'b1) begin n_fail++; $display("FAIL rst_pre_waiting: got %0d want 1", bus.alu_waiting); end
    #2 rst_in = 1'b1;
    #1;
    n_checks++; if (bus.alu_waiting !== 1'b0) begin n_fail++; $display("FAIL rst_async_waiting: got %0d want 0", bus.alu_waiting); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_out: got %0d want 0", bus.out_valid); end
    n_checks++; if (bus.rs_full !== 1'b0) begin n_fail++; $display("FAIL rst_async_full: got %0d want 0", bus.rs_full); end
    #2 rst_in = 1'b0;
    tick();
    bus.lsb_valid = 1'b1; bus.lsb_tag = 4'd8; bus.lsb_value = 32'd50;
    tick();
    idle();
    tick();
    n_checks++; if (bus.alu_waiting !== 1'b0) begin n_fail++; $display("FAIL rst_entry_cleared: got %0d want 0", bus.alu_waiting); end
    tick();
    tick();
  endtask

  task automatic test_addi();
    do_issue(6'b000001, 32'd5, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd7, 4'd3);
    tick();
    idle();
    n_checks++; if (bus.alu_waiting !== 1'b0) begin n_fail++; $display("FAIL addi_early: got %0d want 0", bus.alu_waiting); end
    tick();
    n_checks++; if (bus.alu_waiting !== 1'b1 || bus.alu_vj !== 32'd5 || bus.alu_imm !== 32'd7 || bus.alu_op !== 6'b000001)
      begin n_fail++; $display("FAIL addi_dispatch: w=%0d vj=%0d imm=%0d op=%0h want 1/5/7/01", bus.alu_waiting, bus.alu_vj, bus.alu_imm, bus.alu_op); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_out_early: got %0d want 0", bus.out_valid); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_tag !== 4'd3 || bus.out_value !== 32'd12)
      begin n_fail++; $display("FAIL addi_result: v=%0d tag=%0d val=%0d want 1/3/12", bus.out_valid, bus.out_tag, bus.out_value); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_single: got %0d want 0", bus.out_valid); end
  endtask

  task automatic test_lsb_wakeup();
    do_issue(6'b000011, 32'd0, 1'b1, 4'd5, 32'd4, 1'b0, 4'd0, 32'd0, 4'd1);
    tick();
    idle();
    tick();
    tick();
    tick();
    bus.lsb_valid = 1'b1; bus.lsb_tag = 4'd5; bus.lsb_value = 32'd10;
    n_checks++; if (bus.alu_waiting !== 1'b0) begin n_fail++; $display("FAIL lsb_pending_hold: got %0d want 0", bus.alu_waiting); end
    tick();
    idle();
    n_checks++; if (bus.alu_waiting !== 1'b0) begin n_fail++; $display("FAIL lsb_wake_early: got %0d want 0", bus.alu_waiting); end
    tick();
    n_checks++; if (bus.alu_waiting !== 1'b1 || bus.alu_vj !== 32'd10 || bus.alu_vk !== 32'd4)
      begin n_fail++; $display("FAIL lsb_dispatch: w=%0d vj=%0d vk=%0d want 1/10/4", bus.alu_waiting, bus.alu_vj, bus.alu_vk); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_tag !== 4'd1 || bus.out_value !== 32'd14)
      begin n_fail++; $display("FAIL lsb_result: v=%0d tag=%0d val=%0d want 1/1/14", bus.out_valid, bus.out_tag, bus.out_value); end
    tick();
  endtask

  task automatic test_issue_forward();
    do_issue(6'b000001, 32'd9, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 4'd2);
    tick();
    idle();
    tick();
    tick();
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_tag !== 4'd2 || bus.out_value !== 32'd9)
      begin n_fail++; $display("FAIL fwd_producer: v=%0d tag=%0d val=%0d want 1/2/9", bus.out_valid, bus.out_tag, bus.out_value); end
    // LSB claims the same tag with a different value; the ALU result must be taken.
    do_issue(6'b100011, 32'd0, 1'b1, 4'd2, 32'd3, 1'b0, 4'd0, 32'd0, 4'd4);
    bus.lsb_valid = 1'b1; bus.lsb_tag = 4'd2; bus.lsb_value = 32'd100;
    tick();
    idle();
    tick();
    n_checks++; if (bus.alu_waiting !== 1'b1 || bus.alu_vj !== 32'd9)
      begin n_fail++; $display("FAIL fwd_dispatch: w=%0d vj=%0d want 1/9", bus.alu_waiting, bus.alu_vj); end
    tick();
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_tag !== 4'd4 || bus.out_value !== 32'd6)
      begin n_fail++; $display("FAIL fwd_result: v=%0d tag=%0d val=%0d want 1/4/6", bus.out_valid, bus.out_tag, bus.out_value); end
    tick();
  endtask

  task automatic test_stall();
    bus.rdy_in = 1'b0;
    do_issue(6'b000001, 32'd1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd1, 4'd1);
    tick();
    idle();
    bus.rdy_in = 1'b1;
    tick();
    tick();
    n_checks++; if (bus.alu_waiting !== 1'b0) begin n_fail++; $display("FAIL stall_issue_ignored: got %0d want 0", bus.alu_waiting); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 16; i++) begin
      do_issue(6'b000011, 32'd0, 1'b1, 4'd7, i, 1'b0, 4'd0, 32'd0, i[3:0]);
      tick();
      if (i == 14) begin
        n_checks++; if (bus.rs_full !== 1'b0) begin n_fail++; $display("FAIL full_15: got %0d want 0", bus.rs_full); end
      end
    end
    n_checks++; if (bus.rs_full !== 1'b1) begin n_fail++; $display("FAIL full_16: got %0d want 1", bus.rs_full); end
    do_issue(6'b000011, 32'd100, 1'b0, 4'd0, 32'd200, 1'b0, 4'd0, 32'd0, 4'd15);
    tick();
    idle();
    tick();
    n_checks++; if (bus.alu_waiting !== 1'b0 || bus.rs_full !== 1'b1)
      begin n_fail++; $display("FAIL full_drop: w=%0d full=%0d want 0/1", bus.alu_waiting, bus.rs_full); end
    bus.lsb_valid = 1'b1; bus.lsb_tag = 4'd7; bus.lsb_value = 32'd1000;
    tick();
    idle();
    n_checks++; if (bus.rs_full !== 1'b1) begin n_fail++; $display("FAIL full_wake: got %0d want 1", bus.rs_full); end
    for (int j = 0; j < 16; j++) begin
      tick();
      n_checks++; if (bus.alu_waiting !== 1'b1 || bus.alu_vk !== j || bus.alu_vj !== 32'd1000)
        begin n_fail++; $display("FAIL full_order_%0d: w=%0d vk=%0d vj=%0d want 1/%0d/1000", j, bus.alu_waiting, bus.alu_vk, bus.alu_vj, j); end
      if (j == 0) begin
        n_checks++; if (bus.rs_full !== 1'b0) begin n_fail++; $display("FAIL full_release: got %0d want 0", bus.rs_full); end
      end
    end
    tick();
    n_checks++; if (bus.alu_waiting !== 1'b0) begin n_fail++; $display("FAIL full_17th: got %0d want 0", bus.alu_waiting); end
    tick();
    tick();
  endtask

  task automatic test_flush();
    do_issue(6'b000001, 32'd1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd2, 4'd6);
    tick();
    do_issue(6'b000011, 32'd0, 1'b1, 4'd9, 32'd1, 1'b0, 4'd0, 32'd0, 4'd7);
    tick();
    idle();
    n_checks++; if (bus.alu_waiting !== 1'b1) begin n_fail++; $display("FAIL flush_pre: got %0d want 1", bus.alu_waiting); end
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    n_checks++; if (bus.alu_waiting !== 1'b0 || bus.out_valid !== 1'b0 || bus.rs_full !== 1'b0)
      begin n_fail++; $display("FAIL flush_clear: w=%0d out=%0d full=%0d want 0/0/0", bus.alu_waiting, bus.out_valid, bus.rs_full); end
    bus.lsb_valid = 1'b1; bus.lsb_tag = 4'd9; bus.lsb_value = 32'd3;
    tick();
    idle();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_suppress: got %0d want 0", bus.out_valid); end
    tick();
    n_checks++; if (bus.alu_waiting !== 1'b0) begin n_fail++; $display("FAIL flush_entries: got %0d want 0", bus.alu_waiting); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    n_checks           = 0;
    n_fail             = 0;
    bus.rdy_in         = 1'b1;
    bus.flush          = 1'b0;
    bus.issue_valid    = 1'b0;
    bus.issue_op       = '0;
    bus.issue_vj       = '0;
    bus.issue_qj_valid = 1'b0;
    bus.issue_qj       = '0;
    bus.issue_vk       = '0;
    bus.issue_qk_valid = 1'b0;
    bus.issue_qk       = '0;
    bus.issue_imm      = '0;
    bus.issue_tag      = '0;
    bus.lsb_valid      = 1'b0;
    bus.lsb_tag        = '0;
    bus.lsb_value      = '0;
    test_reset();
    test_addi();
    test_lsb_wakeup();
    test_issue_forward();
    test_stall();
    test_full();
    test_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
